// File: rtl/trackball_encoder.sv
// trackball_encoder: turns signed relative mouse motion into LETA-style
// direction/count-clock pulse pairs, one pair per axis.
//   clk, reset_n      : 10 MHz clock, async active-low reset
//   enable            : low clears the accumulators and ignores strobes
//   mouse_strobe      : one-cycle valid for mouse_dx / mouse_dy
//   mouse_dx/mouse_dy : signed 9-bit motion deltas
//   HD/HC, VD/VC      : direction (1 = positive) and count clock per axis
// Each axis accumulates motion with saturation and drains it one count per
// count-clock pulse, paced by a shared prescaler tick.

// Per-axis accumulator plus direction/count-clock pulse generator.
module trackball_axis #(
  parameter int unsigned ACC_W  = 10,
  parameter bit          NEGATE = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable_i,
  input  logic              tick_i,
  input  logic              strobe_i,
  input  logic signed [8:0] delta_i,
  output logic              dir_o,
  output logic              cnt_clk_o
);

  // Sum is wide enough for acc + 9-bit delta - 1 without overflow.
  localparam int unsigned SUM_W = ((ACC_W > 10) ? ACC_W : 10) + 2;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_MIN = -ACC_MAX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_e;

  state_e                   state_q;
  logic                     d_q;
  logic                     c_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [SUM_W-1:0]  delta_c;
  logic signed [SUM_W-1:0]  consume_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic                     acc_nz_c;
  logic                     acc_pos_c;
  logic                     match_c;
  logic                     enter_high_c;

  // Sign of the pending motion and whether it continues the current direction.
  assign acc_nz_c  = |acc_q;
  assign acc_pos_c = acc_nz_c & ~acc_q[ACC_W-1];
  assign match_c   = d_q ? acc_pos_c : acc_q[ACC_W-1];

  // A count is consumed on the same tick that the count clock rises.
  assign enter_high_c = tick_i & enable_i &
                        ((state_q == SETUP) | ((state_q == LOW) & match_c));

  // Saturating accumulate: strobe delta and consume land in one sum.
  always_comb begin
    delta_c = SUM_W'(delta_i);
    if (NEGATE) delta_c = -delta_c;
    if (!(strobe_i && enable_i)) delta_c = '0;
    consume_c = '0;
    if (enter_high_c) consume_c = d_q ? SUM_W'(1) : -SUM_W'(1);
    sum_c = SUM_W'(acc_q) + delta_c - consume_c;
    if (!enable_i)            acc_d = '0;
    else if (sum_c > ACC_MAX) acc_d = ACC_W'(ACC_MAX);
    else if (sum_c < ACC_MIN) acc_d = ACC_W'(ACC_MIN);
    else                      acc_d = ACC_W'(sum_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

  // Pulse FSM: D only moves on entry to SETUP, so it is never changed while C is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      d_q     <= 1'b0;
      c_q     <= 1'b0;
    end else if (tick_i) begin
      case (state_q)
        IDLE: begin
          if (enable_i && acc_nz_c) begin
            d_q     <= acc_pos_c;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          // Dropping enable before C rises abandons the pulse.
          if (enable_i) begin
            c_q     <= 1'b1;
            state_q <= HIGH;
          end else begin
            state_q <= IDLE;
          end
        end
        HIGH: begin
          c_q     <= 1'b0;
          state_q <= LOW;
        end
        LOW: begin
          if (enable_i && match_c) begin
            c_q     <= 1'b1;
            state_q <= HIGH;
          end else if (enable_i && acc_nz_c) begin
            d_q     <= acc_pos_c;
            state_q <= SETUP;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dir_o     = d_q;
  assign cnt_clk_o = c_q;

endmodule

module trackball_encoder #(
  parameter int unsigned STEP_DIV = 250,
  parameter int unsigned ACC_W    = 10,
  parameter bit          INVERT_Y = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       mouse_strobe,
  input  logic [8:0] mouse_dx,
  input  logic [8:0] mouse_dy,
  output logic       HD,
  output logic       HC,
  output logic       VD,
  output logic       VC
);

  localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             tick_c;

  // Shared step prescaler, 0..STEP_DIV-1.
  assign tick_c = (cnt_q == CNT_W'(STEP_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    cnt_q <= '0;
    else if (tick_c) cnt_q <= '0;
    else             cnt_q <= cnt_q + CNT_W'(1);
  end

  trackball_axis #(.ACC_W(ACC_W), .NEGATE(1'b0)) u_axis_h (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable_i  (enable),
    .tick_i    (tick_c),
    .strobe_i  (mouse_strobe),
    .delta_i   (mouse_dx),
    .dir_o     (HD),
    .cnt_clk_o (HC)
  );

  trackball_axis #(.ACC_W(ACC_W), .NEGATE(INVERT_Y)) u_axis_v (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable_i  (enable),
    .tick_i    (tick_c),
    .strobe_i  (mouse_strobe),
    .delta_i   (mouse_dy),
    .dir_o     (VD),
    .cnt_clk_o (VC)
  );

endmodule

// File: tb/tb_trackball_encoder.sv
// Directed bench for trackball_encoder with STEP_DIV = 4 (one pulse = 8 cycles).
module tb_trackball_encoder;

  localparam int unsigned STEP = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       mouse_strobe;
  logic [8:0] mouse_dx;
  logic [8:0] mouse_dy;
  logic       HD, HC, VD, VC;

  int n_checks = 0;
  int n_fail   = 0;

  trackball_encoder #(.STEP_DIV(STEP), .ACC_W(10), .INVERT_Y(1'b1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .mouse_strobe (mouse_strobe),
    .mouse_dx     (mouse_dx),
    .mouse_dy     (mouse_dy),
    .HD           (HD),
    .HC           (HC),
    .VD           (VD),
    .VC           (VC)
  );

  always #5 clk = ~clk;

  // Cumulative waveform statistics sampled on the falling edge.
  int h_rises = 0, h_rises_neg = 0, v_rises = 0, v_rises_neg = 0;
  int width_bad = 0, gap_bad = 0, toggle_bad = 0, age_bad = 0;
  int h_hi = 0, h_lo = 100, v_hi = 0, v_lo = 100, h_age = 0, v_age = 0;
  logic p_hc = 1'b0, p_hd = 1'b0, p_vc = 1'b0, p_vd = 1'b0;

  always @(negedge clk) begin
    if (HD !== p_hd) h_age = 0; else if (h_age < 1000) h_age++;
    if (VD !== p_vd) v_age = 0; else if (v_age < 1000) v_age++;
    if (HC && p_hc && (HD !== p_hd)) toggle_bad++;
    if (VC && p_vc && (VD !== p_vd)) toggle_bad++;
    if (HC && !p_hc) begin
      h_rises++;
      if (!HD) h_rises_neg++;
      if (h_age < STEP) age_bad++;
      if (h_lo < STEP) gap_bad++;
      h_hi = 1;
    end else if (HC) h_hi++;
    if (!HC && p_hc) begin
      if (h_hi != STEP) width_bad++;
      h_lo = 1;
    end else if (!HC && h_lo < 1000) h_lo++;
    if (VC && !p_vc) begin
      v_rises++;
      if (!VD) v_rises_neg++;
      if (v_age < STEP) age_bad++;
      if (v_lo < STEP) gap_bad++;
      v_hi = 1;
    end else if (VC) v_hi++;
    if (!VC && p_vc) begin
      if (v_hi != STEP) width_bad++;
      v_lo = 1;
    end else if (!VC && v_lo < 1000) v_lo++;
    p_hc = HC; p_hd = HD; p_vc = VC; p_vd = VD;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic strobe(input logic [8:0] dx, input logic [8:0] dy);
    @(negedge clk);
    mouse_strobe = 1'b1; mouse_dx = dx; mouse_dy = dy;
    @(negedge clk);
    mouse_strobe = 1'b0; mouse_dx = '0; mouse_dy = '0;
  endtask

  task automatic wait_hc_high(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (HC) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset;
    int h0;
    reset_n = 1'b0; enable = 1'b1;
    strobe(9'd7, 9'd7);
    strobe(9'd3, 9'(-5));
    @(negedge clk);
    n_checks++;
    if ({HD, HC, VD, VC} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 0000", {HD, HC, VD, VC});
    end
    h0 = h_rises + v_rises;
    reset_n = 1'b1;
    repeat (20 * STEP) @(negedge clk);
    n_checks++;
    if (h_rises + v_rises - h0 !== 0) begin
      n_fail++; $display("FAIL reset_no_edges: got %0d edges expected 0", h_rises + v_rises - h0);
    end
  endtask

  task automatic test_positive_burst;
    int h0 = h_rises, n0 = h_rises_neg, v0 = v_rises, w0 = width_bad, a0 = age_bad;
    strobe(9'd3, 9'd0);
    repeat (100) @(negedge clk);
    n_checks++;
    if (h_rises - h0 !== 3) begin
      n_fail++; $display("FAIL burst_rises: got %0d expected 3", h_rises - h0);
    end
    n_checks++;
    if (h_rises_neg - n0 !== 0) begin
      n_fail++; $display("FAIL burst_dir: got %0d rises with HD=0 expected 0", h_rises_neg - n0);
    end
    n_checks++;
    if (width_bad - w0 !== 0) begin
      n_fail++; $display("FAIL burst_width: got %0d bad widths expected 0", width_bad - w0);
    end
    n_checks++;
    if (age_bad - a0 !== 0) begin
      n_fail++; $display("FAIL burst_setup: got %0d short HD setups expected 0", age_bad - a0);
    end
    n_checks++;
    if (v_rises - v0 !== 0 || HC !== 1'b0) begin
      n_fail++; $display("FAIL burst_idle: got VC edges %0d HC %b expected 0 0", v_rises - v0, HC);
    end
  endtask

  task automatic test_reversal;
    int h0 = h_rises, n0 = h_rises_neg, t0 = toggle_bad, a0 = age_bad;
    bit ok;
    strobe(9'd2, 9'd0);
    wait_hc_high(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rev_first_rise: got timeout expected HC rise"); end
    strobe(9'(-5), 9'd0);
    repeat (150) @(negedge clk);
    n_checks++;
    if (h_rises - h0 !== 5) begin
      n_fail++; $display("FAIL rev_rises: got %0d expected 5", h_rises - h0);
    end
    n_checks++;
    if (h_rises_neg - n0 !== 4) begin
      n_fail++; $display("FAIL rev_neg_rises: got %0d expected 4", h_rises_neg - n0);
    end
    n_checks++;
    if (toggle_bad - t0 !== 0 || age_bad - a0 !== 0) begin
      n_fail++; $display("FAIL rev_hd_stable: got toggles %0d short setups %0d expected 0 0",
                         toggle_bad - t0, age_bad - a0);
    end
    n_checks++;
    if (HD !== 1'b0) begin n_fail++; $display("FAIL rev_hd_final: got %b expected 0", HD); end
  endtask

  task automatic test_saturation;
    int v0 = v_rises, n0 = v_rises_neg, h0 = h_rises, w0 = width_bad, g0 = gap_bad;
    @(negedge clk);
    mouse_strobe = 1'b1; mouse_dy = 9'(-256);
    repeat (3) @(negedge clk);
    mouse_strobe = 1'b0; mouse_dy = '0;
    repeat (511 * 2 * STEP + 100) @(negedge clk);
    n_checks++;
    if (v_rises - v0 !== 511) begin
      n_fail++; $display("FAIL sat_rises: got %0d expected 511", v_rises - v0);
    end
    n_checks++;
    if (v_rises_neg - n0 !== 0 || VD !== 1'b1) begin
      n_fail++; $display("FAIL sat_dir: got neg rises %0d VD %b expected 0 1", v_rises_neg - n0, VD);
    end
    n_checks++;
    if (width_bad - w0 !== 0 || gap_bad - g0 !== 0 || h_rises - h0 !== 0) begin
      n_fail++; $display("FAIL sat_shape: got width %0d gap %0d HC edges %0d expected 0 0 0",
                         width_bad - w0, gap_bad - g0, h_rises - h0);
    end
  endtask

  // Second strobe is sampled on the very edge where the second pulse consumes.
  task automatic test_collision;
    int h0 = h_rises;
    bit ok;
    strobe(9'd2, 9'd0);
    wait_hc_high(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL col_first_rise: got timeout expected HC rise"); end
    repeat (2 * STEP - 2) @(negedge clk);
    strobe(9'd3, 9'd0);
    repeat (100) @(negedge clk);
    n_checks++;
    if (h_rises - h0 !== 5) begin
      n_fail++; $display("FAIL col_rises: got %0d expected 5", h_rises - h0);
    end
  endtask

  task automatic test_enable_drop;
    int h0 = h_rises, w0 = width_bad;
    bit ok;
    strobe(9'd5, 9'd0);
    wait_hc_high(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL en_first_rise: got timeout expected HC rise"); end
    @(negedge clk);
    enable = 1'b0;
    repeat (60) @(negedge clk);
    n_checks++;
    if (h_rises - h0 !== 1 || width_bad - w0 !== 0) begin
      n_fail++; $display("FAIL en_drop: got rises %0d bad widths %0d expected 1 0",
                         h_rises - h0, width_bad - w0);
    end
    strobe(9'd3, 9'd0);
    repeat (60) @(negedge clk);
    enable = 1'b1;
    repeat (60) @(negedge clk);
    n_checks++;
    if (h_rises - h0 !== 1) begin
      n_fail++; $display("FAIL en_ignored: got rises %0d expected 1", h_rises - h0);
    end
    strobe(9'd2, 9'd0);
    repeat (60) @(negedge clk);
    n_checks++;
    if (h_rises - h0 !== 3) begin
      n_fail++; $display("FAIL en_resume: got rises %0d expected 3", h_rises - h0);
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1;
    mouse_strobe = 1'b0; mouse_dx = '0; mouse_dy = '0;
    test_reset();
    test_positive_burst();
    test_reversal();
    test_saturation();
    test_collision();
    test_enable_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trackball_encoder.md
# trackball_encoder

Converts signed relative mouse motion from the MiSTer HPS into the direction/clock pulse pairs that the LETA trackball decoder consumes (tb1VD/tb1VC, tb1HD/tb1HC), so a USB mouse can stand in for the Crystal Castles trackball. It sits between the framework's mouse report interface and the LETA inputs in the top level, in the 10 MHz `clk` domain. Each axis has a saturating motion accumulator. A per-axis pulse FSM drains the accumulator one count per emitted clock pulse at a fixed, parameterised step rate.

## Interface
Parameters:
- STEP_DIV, 250, `clk` cycles per step tick; the step tick is 40 kHz at 10 MHz, so one full output pulse takes 2 ticks (20 kHz max count rate).
- ACC_W, 10, accumulator width, signed two's complement.
- INVERT_Y, 1, when 1 the dy input is negated before accumulation.

Ports:
- clk, in, 1, system clock (10 MHz).
- reset_n, in, 1, asynchronous active-low reset.
- enable, in, 1, when low, accumulators are cleared and strobes are ignored.
- mouse_strobe, in, 1, single-cycle pulse: dx/dy are valid this cycle.
- mouse_dx, in, 9, signed horizontal delta.
- mouse_dy, in, 9, signed vertical delta.
- HD, out, 1, horizontal direction (1 = positive motion).
- HC, out, 1, horizontal count clock; the rising edge counts.
- VD, out, 1, vertical direction.
- VC, out, 1, vertical count clock.

## Operation
- Prescaler:
  - Counts 0..STEP_DIV-1 and wraps.
  - `tick` is high for one cycle when the count equals STEP_DIV-1.
  - Both axes share the same tick.
- Accumulation, per axis, every cycle:
  - acc_next = sat(acc + delta − consume).
  - delta is the sign-extended dx (or dy, negated if INVERT_Y) when mouse_strobe & enable, else 0.
  - consume is +1 if the FSM enters HIGH with D=1, −1 if it enters HIGH with D=0, else 0.
  - sat clamps to [−(2^(ACC_W−1)−1), +(2^(ACC_W−1)−1)], i.e. ±511. The most negative code is never produced.
- Pulse FSM, per axis, transitions only on tick:
  - IDLE: if acc ≠ 0, D ← (acc > 0) and go to SETUP; else stay. C = 0.
  - SETUP: C ← 1, consume one count, go to HIGH. Holding one tick here guarantees D is stable for ≥1 tick before the C rising edge.
  - HIGH: C ← 0, go to LOW.
  - LOW:
    - If acc ≠ 0 and sign(acc) matches D: C ← 1, consume, go to HIGH (back-to-back pulses, no setup tick).
    - Else if acc ≠ 0: D ← (acc > 0), go to SETUP.
    - Else go to IDLE.
- D changes only in IDLE→SETUP or LOW→SETUP, never while C = 1.
- enable low:
  - Accumulators are forced to 0 every cycle.
  - An in-flight pulse completes normally (HIGH→LOW→IDLE); no new pulse starts.
- Axes are fully independent except for the shared tick.

## Timing
- Reset values: HD = HC = VD = VC = 0, both acc = 0, both FSMs IDLE, prescaler = 0.
- All outputs are registered, with no combinational path from inputs.
- Latency from a strobe to the first C rising edge:
  - The accumulator updates on the strobe's clock edge.
  - The FSM sees acc ≠ 0 at the next tick (IDLE→SETUP).
  - C rises at the following tick.
  - Worst case is 2·STEP_DIV + 1 cycles.
- C pulse: high exactly STEP_DIV cycles; low ≥ STEP_DIV cycles between pulses.
- Simultaneous strobe and consume in the same cycle: both apply in one saturating sum.
- A strobe while the FSM is in HIGH does not alter the current pulse.
- Reset asserted mid-pulse: outputs drop to 0 asynchronously and all counts are lost.

## Test plan
Benches use STEP_DIV = 4.
- Reset: hold reset_n low with strobes applied → all outputs 0; after release, no C edge for 20 ticks.
- Positive burst: strobe dx = +3 → HD = 1 set one tick before the first HC rise; exactly 3 HC rising edges, each high 4 cycles; HC idle afterwards; VC untouched.
- Direction reversal: strobe dx = +2, then dx = −5 after the first HC rise → accumulator goes 1 → −4. After that pulse completes, HD falls to 0 one tick before the next rise. Exactly 4 further edges with HD = 0. HD never toggles while HC = 1.
- Saturation: strobe dy = −256 three times back-to-back with INVERT_Y = 1 → VD = 1 and acc clamps at +511. Exactly 511 VC edges follow.
- Collision: a strobe coinciding with the consume cycle → net acc equals the arithmetic sum. The total edge count matches the sum of deltas.
- enable drop mid-pulse → current pulse completes with full high width; no further edges; later strobes are ignored until enable = 1.
